// File: rtl/calc_core.sv
// Sequential calculator: add/sub/shift-add multiply into a 3-digit BCD result via double-dabble.
// Optional display refresh counter on sel when CALC_REFRESH_EN is defined (sel tied low otherwise).
module calc_core #(
   parameter int WIDTH        = 4,
   parameter int REFRESH_BITS = 17
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             add,
   input  logic             sub,
   input  logic             mult,
   input  logic             squared,
   output logic [WIDTH-1:0] zero,
   output logic [WIDTH-1:0] one,
   output logic [WIDTH-1:0] two,
   output logic             sign,
   output logic             busy,
   output logic             done,
   output logic             sel
);

   localparam int RW = 2 * WIDTH;
   localparam int SW = 12 + RW;
   localparam logic [7:0] MUL_LAST  = 8'(WIDTH - 1);
   localparam logic [7:0] CONV_LAST = 8'(RW - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      CONV = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD  = 2'd0,
      OP_SUB  = 2'd1,
      OP_MULT = 2'd2,
      OP_SQR  = 2'd3
   } op_t;

   state_t            state_r;
   state_t            state_s;
   op_t               op_r;
   op_t               op_s;
   logic [3:0]        btn_r;
   logic [3:0]        edge_s;
   logic              start_s;
   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   logic [RW-1:0]     mcand_r;
   logic [WIDTH-1:0]  mplier_r;
   logic [RW-1:0]     acc_r;
   logic [11:0]       bcd_r;
   logic [7:0]        cnt_r;
   logic              neg_r;
   logic [RW-1:0]     sum_s;
   logic [RW-1:0]     diff_s;
   logic [RW-1:0]     pp_s;
   logic [11:0]       adj_s;
   logic [SW-1:0]     shift_s;

   // Add 3 to every BCD digit that is 5 or more, ahead of the doubling shift
   function automatic logic [11:0] dabble_adj(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      for (int i = 0; i < 3; i++) begin
         if (v[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd3;
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction

   // Rising-edge detection and priority selection of the requested operation
   always_comb begin
      edge_s  = {squared, mult, sub, add} & ~btn_r;
      start_s = (state_r == IDLE) && (edge_s != 4'b0000);
      if (edge_s[3]) begin
         op_s = OP_SQR;
      end else if (edge_s[2]) begin
         op_s = OP_MULT;
      end else if (edge_s[1]) begin
         op_s = OP_SUB;
      end else begin
         op_s = OP_ADD;
      end
   end

   // Arithmetic and conversion datapath terms
   always_comb begin
      sum_s = RW'(a_r) + RW'(b_r);
      if (b_r > a_r) begin
         diff_s = RW'(b_r - a_r);
      end else begin
         diff_s = RW'(a_r - b_r);
      end
      if (mplier_r[0]) begin
         pp_s = acc_r + mcand_r;
      end else begin
         pp_s = acc_r;
      end
      adj_s   = dabble_adj(bcd_r);
      shift_s = {adj_s, acc_r} << 1;
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_s) begin
               state_s = EXEC;
            end else begin
               state_s = IDLE;
            end
         end
         EXEC: begin
            if ((op_r == OP_ADD) || (op_r == OP_SUB)) begin
               state_s = CONV;
            end else if (cnt_r == MUL_LAST) begin
               state_s = CONV;
            end else begin
               state_s = EXEC;
            end
         end
         CONV: begin
            if (cnt_r == CONV_LAST) begin
               state_s = DONE;
            end else begin
               state_s = CONV;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Button tracking, operand latch, working registers and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_r    <= 4'b0000;
         op_r     <= OP_ADD;
         a_r      <= '0;
         b_r      <= '0;
         mcand_r  <= '0;
         mplier_r <= '0;
         acc_r    <= '0;
         bcd_r    <= 12'd0;
         cnt_r    <= 8'd0;
         neg_r    <= 1'b0;
         zero     <= '0;
         one      <= '0;
         two      <= '0;
         sign     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         btn_r <= {squared, mult, sub, add};
         busy  <= (state_s != IDLE);
         done  <= (state_s == DONE);
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  op_r     <= op_s;
                  a_r      <= a;
                  b_r      <= b;
                  mcand_r  <= RW'(a);
                  mplier_r <= (op_s == OP_SQR) ? a : b;
                  acc_r    <= '0;
                  bcd_r    <= 12'd0;
                  cnt_r    <= 8'd0;
                  neg_r    <= 1'b0;
               end
            end
            EXEC: begin
               case (op_r)
                  OP_ADD: begin
                     acc_r <= sum_s;
                     neg_r <= 1'b0;
                  end
                  OP_SUB: begin
                     acc_r <= diff_s;
                     neg_r <= (b_r > a_r);
                  end
                  default: begin
                     acc_r    <= pp_s;
                     mcand_r  <= mcand_r << 1;
                     mplier_r <= mplier_r >> 1;
                     neg_r    <= 1'b0;
                  end
               endcase
               cnt_r <= (state_s == CONV) ? 8'd0 : cnt_r + 8'd1;
            end
            CONV: begin
               bcd_r <= shift_s[SW-1:RW];
               acc_r <= shift_s[RW-1:0];
               cnt_r <= cnt_r + 8'd1;
               // Final shift lands directly in the display digits
               if (state_s == DONE) begin
                  zero <= WIDTH'(shift_s[RW+3:RW]);
                  one  <= WIDTH'(shift_s[RW+7:RW+4]);
                  two  <= WIDTH'(shift_s[RW+11:RW+8]);
                  sign <= neg_r;
               end
            end
            DONE: begin
               cnt_r <= 8'd0;
            end
            default: begin
               cnt_r <= 8'd0;
            end
         endcase
      end
   end

`ifdef CALC_REFRESH_EN
   logic [REFRESH_BITS-1:0] refresh_r;

   // Free-running display refresh counter; its MSB selects the digit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         refresh_r <= '0;
      end else begin
         refresh_r <= refresh_r + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      end
   end

   assign sel = refresh_r[REFRESH_BITS-1];
`else
   assign sel = 1'b0;
`endif

endmodule

// File: tb/tb_calc_core.sv
// Randomized self-checking bench for calc_core against an arithmetic reference model.
module tb_calc_core;
   localparam int W  = 4;
   localparam int RB = 3;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] a, b;
   logic         add, sub, mult, squared;
   logic [W-1:0] zero, one, two;
   logic         sign, busy, done, sel;

   int total = 0;
   int bad   = 0;
   int cyc;

   calc_core #(.WIDTH(W), .REFRESH_BITS(RB)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b),
      .add(add), .sub(sub), .mult(mult), .squared(squared),
      .zero(zero), .one(one), .two(two),
      .sign(sign), .busy(busy), .done(done), .sel(sel)
   );

   always #5 clk = ~clk;

   // cycles since reset release, for the expected display select
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int exp_sel();
`ifdef CALC_REFRESH_EN
      return (cyc / (1 << (RB - 1))) % 2;
`else
      return 0;
`endif
   endfunction

   // Reference: priority pick, plain arithmetic result, and documented latency
   task automatic model(input logic [3:0] btns, input int x, input int y,
                        output int mag, output int neg, output int lat);
      neg = 0;
      if (btns[3]) begin
         mag = x * x; lat = 13;
      end else if (btns[2]) begin
         mag = x * y; lat = 13;
      end else if (btns[1]) begin
         mag = (x > y) ? x - y : y - x; neg = (y > x) ? 1 : 0; lat = 10;
      end else begin
         mag = x + y; lat = 10;
      end
   endtask

   task automatic run_op(input logic [3:0] btns, input int x, input int y,
                         input int hold, input int inject, input string tag);
      int mag, neg, lat, first, ndone;
      first = -1;
      ndone = 0;
      model(btns, x, y, mag, neg, lat);
      @(negedge clk);
      a = W'(x);
      b = W'(y);
      {squared, mult, sub, add} = btns;
      for (int n = 1; n <= 2 * lat + 2; n++) begin
         @(negedge clk);
         if (n == 1) begin
            a = W'($urandom);
            b = W'($urandom);
            check({tag, ".busy"}, busy, 1);
         end
         if (n == hold) {squared, mult, sub, add} = 4'b0000;
         if (inject != 0 && n == inject) add = 1'b1;
         if (inject != 0 && n == inject + 1) add = 1'b0;
         if (done) begin
            ndone++;
            if (first < 0) first = n;
         end
         if (n == lat + 1) check({tag, ".sel"}, sel, exp_sel());
      end
      {squared, mult, sub, add} = 4'b0000;
      check({tag, ".cycle"}, first, lat);
      check({tag, ".ndone"}, ndone, 1);
      check({tag, ".zero"}, zero, mag % 10);
      check({tag, ".one"}, one, (mag / 10) % 10);
      check({tag, ".two"}, two, mag / 100);
      check({tag, ".sign"}, sign, neg);
      check({tag, ".idle"}, busy, 0);
   endtask

   initial begin
      int ndone;
      reset = 1'b1;
      a = '0; b = '0;
      {squared, mult, sub, add} = 4'b0000;
      repeat (3) @(negedge clk);
      check("rst.zero", zero, 0);
      check("rst.one", one, 0);
      check("rst.two", two, 0);
      check("rst.sign", sign, 0);
      check("rst.busy", busy, 0);
      check("rst.done", done, 0);
      check("rst.sel", sel, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("idle.busy", busy, 0);
      check("idle.sel", sel, exp_sel());

      run_op(4'b0001, 7, 8, 1, 0, "add78");
      run_op(4'b0010, 3, 9, 1, 0, "sub39");
      run_op(4'b0100, 15, 15, 1, 0, "mul15");
      run_op(4'b1000, 12, int'($urandom_range(0, 15)), 2, 0, "sq12");
      run_op(4'b0101, 5, 6, 1, 3, "prio");

      // abort a multiply with reset in cycle E+6
      ndone = 0;
      @(negedge clk);
      a = 4'd15; b = 4'd15; mult = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (n == 1) mult = 1'b0;
         if (done) ndone++;
      end
      reset = 1'b1;
      #1;
      check("abort.zero", zero, 0);
      check("abort.one", one, 0);
      check("abort.two", two, 0);
      check("abort.sign", sign, 0);
      check("abort.busy", busy, 0);
      check("abort.done", done, 0);
      check("abort.sel", sel, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort.ndone", ndone, 0);
      run_op(4'b0001, 2, 2, 1, 0, "add22");

      for (int i = 0; i < 30; i++) begin
         run_op(4'($urandom_range(1, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), int'($urandom_range(1, 12)), 0, "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/calc_core.md
CALC_CORE -- requirements
Module: calc_core

Interface
REQ-001 Parameter WIDTH, default 4, operand width and BCD digit width.
REQ-002 Parameter REFRESH_BITS, default 17, refresh counter width; used only when CALC_REFRESH_EN is defined.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 a  input  WIDTH  operand A, unsigned.
REQ-006 b  input  WIDTH  operand B, unsigned.
REQ-007 add, sub, mult, squared  input  1 each  operation buttons, level inputs, pre-debounced.
REQ-008 zero  output  WIDTH  BCD ones digit of result magnitude.
REQ-009 one  output  WIDTH  BCD tens digit.
REQ-010 two  output  WIDTH  BCD hundreds digit.
REQ-011 sign  output  1  1 = result negative.
REQ-012 busy  output  1  high while an operation is in progress.
REQ-013 done  output  1  one-cycle pulse when the digit outputs update.
REQ-014 sel  output  1  digit select for the downstream display mux.

Function
REQ-015 Each button shall be registered once per cycle; a start event is button high while its register is low (rising edge), evaluated in IDLE only.
REQ-016 Simultaneous start events shall resolve by priority squared > mult > sub > add.
REQ-017 The FSM states shall be IDLE, EXEC, CONV, DONE.
REQ-018 IDLE: on a start event, latch a, b and opcode, and go to EXEC; otherwise stay.
REQ-019 EXEC for add/sub: 1 cycle; result = a+b, or |a-b| with sign = (b > a); then go to CONV.
REQ-020 EXEC for mult/squared: 4 cycles of shift-add over the multiplier bits; operands are a*b or a*a; sign = 0; then go to CONV.
REQ-021 The result register shall be 2*WIDTH bits wide; no overflow is possible for WIDTH=4 (max 225).
REQ-022 CONV: 8 cycles of double-dabble (add 3 to any nibble >= 5, then shift) over the 8-bit result; then go to DONE.
REQ-023 DONE: zero/one/two/sign shall be loaded on the clock edge entering DONE; done is high for this 1 cycle; then go to IDLE.
REQ-024 Latency from the start-event cycle E: done shall be high in cycle E+10 for add/sub and E+13 for mult/squared.
REQ-025 busy shall be high in EXEC, CONV and DONE, and low in IDLE.
REQ-026 Digit and sign outputs shall hold their last values between operations.
REQ-027 Button edges while busy shall be ignored and not queued; the edge registers keep tracking, so a button held through DONE does not retrigger.
REQ-028 Operand changes after the latch cycle shall not affect the result in progress.

Reset
REQ-029 Reset shall force the state to IDLE and clear zero, one, two, sign, busy, done, sel, the button registers, the working registers and the refresh counter to 0.
REQ-030 Reset asserted mid-operation shall abort the operation with no done pulse; the first start event after release starts a fresh operation.

Configuration
REQ-031 Macro CALC_REFRESH_EN defined: a free-running REFRESH_BITS counter shall run, and sel equals its MSB (sel toggles every 2^(REFRESH_BITS-1) cycles).
REQ-032 Macro CALC_REFRESH_EN undefined: there shall be no counter, and sel shall be constant 0.

Verification
REQ-033 a=7, b=8, pulse add -> done in cycle E+10; two=0, one=1, zero=5, sign=0.
REQ-034 a=3, b=9, pulse sub -> done in cycle E+10; digits 0,0,6; sign=1.
REQ-035 a=15, b=15, pulse mult -> done in cycle E+13; two=2, one=2, zero=5; then squared with a=12 -> digits 1,4,4.
REQ-036 add and mult rising in the same cycle (a=5, b=6) -> mult executes; result 030; exactly one done pulse; an add pulse during busy is ignored.
REQ-037 Start mult, assert reset at E+6 -> all outputs 0, no done pulse; a subsequent add of 2+2 -> 004 at E'+10.
REQ-038 With CALC_REFRESH_EN and REFRESH_BITS=3 -> sel toggles every 4 cycles from reset; without the macro, sel stays 0.
